// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow pulse train in clk_in cycles, with lock and timeout flags.
// Optional lock detection is built when CLK_PERIOD_METER_LOCK_EN is defined.
module clk_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             clr,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   fill_q;
    logic                   s, s_d, rise;
    logic [CNT_W-1:0]       cnt, hcnt;
    logic                   start, capture, expire;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d    <= 1'b0;
            fill_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d    <= sync_q[SYNC_STAGES-1];
            fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // A reset-cleared chain would fake a rise under a high input; only edges
    // between two genuinely sampled values count.
    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d & fill_q[SYNC_STAGES];

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        capture = 1'b0;
        expire  = 1'b0;
        unique case (state_q)
            IDLE: state_d = ARM;
            ARM: begin
                if (rise) begin
                    state_d = MEAS;
                    start   = 1'b1;
                end
            end
            MEAS: begin
                if (rise) begin
                    capture = 1'b1;
                end else if (cnt == CNT_MAX) begin
                    expire  = 1'b1;
                    state_d = ARM;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clr) begin
            state_d = IDLE;
            start   = 1'b0;
            capture = 1'b0;
            expire  = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            hcnt       <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (clr) begin
                cnt       <= '0;
                hcnt      <= '0;
                period    <= '0;
                high_time <= '0;
                timeout   <= 1'b0;
            end else if (start || capture) begin
                cnt  <= CNT_ONE;
                hcnt <= CNT_ONE;
                if (capture) begin
                    period     <= cnt;
                    high_time  <= hcnt;
                    meas_valid <= 1'b1;
                    timeout    <= 1'b0;
                end
            end else if (expire) begin
                timeout <= 1'b1;
            end else if (state_q == MEAS) begin
                cnt  <= cnt + CNT_ONE;
                hcnt <= hcnt + CNT_W'(s);
            end
        end
    end

`ifdef CLK_PERIOD_METER_LOCK_EN
    logic [CNT_W-1:0] prev;
    logic             prev_ok;

    // prev_ok keeps the first measurement after arming from comparing against stale data.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            prev    <= '0;
            prev_ok <= 1'b0;
            locked  <= 1'b0;
        end else if (clr) begin
            prev    <= '0;
            prev_ok <= 1'b0;
            locked  <= 1'b0;
        end else if (capture) begin
            locked  <= prev_ok && (cnt == prev);
            prev    <= cnt;
            prev_ok <= 1'b1;
        end else if (expire) begin
            locked  <= 1'b0;
            prev_ok <= 1'b0;
        end
    end
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed and randomized check of clk_period_meter against a history-based model of the input train.
// Lock expectations follow CLK_PERIOD_METER_LOCK_EN.
module tb_clk_period_meter;

    localparam int CNT_W = 4;
    localparam int S     = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;
    localparam int HN    = 8192;

    logic             clk_in = 1'b0;
    logic             rst_n  = 1'b0;
    logic             sig_in = 1'b0;
    logic             clr    = 1'b0;
    logic [CNT_W-1:0] period, high_time;
    logic             meas_valid, locked, timeout;

    always #5 clk_in = ~clk_in;

    clk_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(S)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .clr        (clr),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .timeout    (timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int k     = 0;
    bit b_hist [HN];
    int rel_start = 0;
    int open_c    = -1;
    int prev      = 0;
    bit have_prev = 1'b0;
    int e_per, e_hi, n_per, n_hi;
    bit e_val, e_lck, e_to, n_val, n_lck, n_to;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s @cycle %0d: observed %0d expected %0d", tag, k, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("period", 32'(period), e_per);
        chk("high_time", 32'(high_time), e_hi);
        chk("meas_valid", 32'(meas_valid), 32'(e_val));
        chk("locked", 32'(locked), 32'(e_lck));
        chk("timeout", 32'(timeout), 32'(e_to));
    endtask

    task automatic model_reset();
        {e_per, e_hi, n_per, n_hi} = '0;
        {e_val, e_lck, e_to, n_val, n_lck, n_to} = '0;
        open_c    = -1;
        have_prev = 1'b0;
    endtask

    // s in cycle c is b_hist[c-S+1]; outputs computed here appear in cycle k+1.
    task automatic advance();
        bit rise;
        int hi;
        n_val = 1'b0;
        n_per = e_per;
        n_hi  = e_hi;
        n_lck = e_lck;
        n_to  = e_to;
        rise  = (k - S >= rel_start) && b_hist[k-S+1] && !b_hist[k-S];
        if (open_c >= 0) begin
            if (rise) begin
                hi = 0;
                for (int c = open_c; c < k; c++) hi += int'(b_hist[c-S+1]);
                n_per = k - open_c;
                n_hi  = hi;
                n_val = 1'b1;
                n_to  = 1'b0;
`ifdef CLK_PERIOD_METER_LOCK_EN
                n_lck = have_prev && (n_per == prev);
`else
                n_lck = 1'b0;
`endif
                prev      = n_per;
                have_prev = 1'b1;
                open_c    = k;
            end else if (k - open_c == MAXC) begin
                n_to      = 1'b1;
                n_lck     = 1'b0;
                have_prev = 1'b0;
                open_c    = -1;
            end
        end else if (rise) begin
            open_c = k;
        end
    endtask

    task automatic step(input bit v, input bit c, input bit r);
        @(negedge clk_in);
        sig_in = v;
        clr    = c;
        if (!r && rst_n) begin
            rst_n = 1'b0;
            #1;
            model_reset();
            check_outputs();
        end else begin
            rst_n = r;
        end
        @(posedge clk_in);
        k++;
        if (k < HN) b_hist[k] = v;
        #1;
        if (!rst_n) begin
            model_reset();
            rel_start = k + 1;
        end else if (clr) begin
            model_reset();
        end else begin
            e_per = n_per;
            e_hi  = n_hi;
            e_val = n_val;
            e_lck = n_lck;
            e_to  = n_to;
        end
        check_outputs();
        if (rst_n && !clr) advance();
    endtask

    task automatic train(input int h, input int l, input int n);
        repeat (n) begin
            repeat (h) step(1'b1, 1'b0, 1'b1);
            repeat (l) step(1'b0, 1'b0, 1'b1);
        end
    endtask

    bit lock_on;

    initial begin
`ifdef CLK_PERIOD_METER_LOCK_EN
        lock_on = 1'b1;
`else
        lock_on = 1'b0;
`endif
        model_reset();
        repeat (3) step(1'b0, 1'b0, 1'b0);

        train(2, 2, 8);
        chk("steady_period", 32'(period), 4);
        chk("steady_high", 32'(high_time), 2);
        chk("steady_locked", 32'(locked), 32'(lock_on));

        train(3, 5, 5);
        chk("p8_period", 32'(period), 8);
        chk("p8_high", 32'(high_time), 3);
        train(3, 3, 4);
        chk("p6_period", 32'(period), 6);
        chk("p6_locked", 32'(locked), 32'(lock_on));

        train(1, 14, 3);
        chk("max_period", 32'(period), MAXC);
        chk("max_timeout", 32'(timeout), 0);
        step(1'b1, 1'b0, 1'b1);
        repeat (20) step(1'b0, 1'b0, 1'b1);
        chk("stall_timeout", 32'(timeout), 1);
        chk("stall_locked", 32'(locked), 0);
        chk("stall_period_held", 32'(period), MAXC);
        train(2, 2, 4);
        chk("resume_timeout", 32'(timeout), 0);

        train(1, 15, 2);

        for (int i = 0; i < 20; i++)
            train(int'($urandom_range(6, 1)), int'($urandom_range(8, 1)),
                  int'($urandom_range(3, 1)));

        repeat (3) step(1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b1);
        train(2, 3, 4);
        chk("start_high_period", 32'(period), 5);

        train(4, 4, 3);
        repeat (2) step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        train(4, 4, 4);

        train(3, 4, 3);
        repeat (2) step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        train(3, 4, 3);
        chk("after_clr_period", 32'(period), 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
